ones_counter_datapath: RTL and testbench
========================================

// Module: ones_counter_datapath
// PURPOSE
//   Datapath half of the ones-counter system; the partner of the ones-counter controller FSM.
//   - Loads an N-bit word from the switches on load_A.
//   - Each cycle shift is high: shifts the word right one bit and adds the bit shifted out to a running count.
//   - Reports completion to the controller on done_datapath.
//   - Drives the binary count on result, which the controller decodes for HEX0.
// PARAMETERS
//   N   8                   width of the input word / shift register
//   CW  $clog2(N+1) (=4)    width of result; must be able to hold the value N
// PORTS
//   clock           input   1    system clock; all state updates on its rising edge
//   reset_datapath  input   1    synchronous, active-high reset
//   load_A          input   1    from controller: capture data_in into A, clear result
//   shift           input   1    from controller: perform one shift/accumulate step
//   data_in         input   N    word to count (SW[N-1:0])
//   done_datapath   output  1    to controller: high while A == 0 (no ones left)
//   result          output  CW   number of ones counted so far (binary)
//   A_out           output  N    current shift-register contents (debug/LEDs)
// BEHAVIOUR
//   State
//   - A [N-1:0]: shift register.
//   - result [CW-1:0]: ones accumulator.
//   - No other storage.
//   Reset (reset_datapath=1 at posedge clock)
//   - A <= 0, result <= 0.
//   - done_datapath therefore reads 1 out of reset (the controller ignores it in idle).
//   - Reset has priority over load_A and shift.
//   Per-edge update, priority reset > load_A > shift > hold
//   - load_A=1: A <= data_in; result <= 0.
//     - shift is ignored in that cycle if also high (the controller never drives both).
//   - shift=1 and A != 0: A <= {1'b0, A[N-1:1]}; result <= result + A[0].
//   - shift=1 and A == 0: hold. No increment, no wrap, result is stable.
//   - Otherwise: hold A and result.
//   Outputs
//   - done_datapath = (A == 0): combinational from the register, no added latency.
//     - Asserts in the same cycle the last '1' leaves A.
//     - The controller sees done on the edge after the final shift.
//   - result and A_out are driven directly from the registers, with no combinational path from inputs.
//   Latency
//   - Counting finishes in (index of highest set bit + 1) shift cycles, at most N.
//   - Early exit: leading zeros above the top set bit are never shifted.
//   - result is final once done_datapath=1 and holds until the next load_A or reset.
//   Arithmetic
//   - result increments by exactly 0 or 1 per shift.
//   - The maximum reachable value is N, so no overflow when CW >= $clog2(N+1).
//   Boundary cases
//   - data_in == 0: after load, done_datapath=1 immediately and result=0.
//   - data_in all ones: N shifts; result = N; done asserts after the Nth shift.
//   - data_in changing while shifting: ignored; only sampled on load_A.
//   - load_A mid-count: restarts cleanly; the old partial result is discarded.
//   - reset mid-count: A=0 and result=0 on the next edge; done_datapath=1.
//   - shift held high after done: no change to A or result.
// TESTING
//   1. Reset -> A_out=0, result=0, done_datapath=1 on the cycle after the reset edge.
//   2. data_in=8'b1011_0100, load_A 1 cycle, then shift held ->
//      done_datapath rises after 8 shifts (top bit 7); result=4; holds 4 with shift still high.
//   3. data_in=8'b0000_0101, load, shift ->
//      A: 05, 02, 01, 00; result: 1, 1, 2; done after 3 shifts (early exit).
//   4. data_in=8'h00, load -> done_datapath=1 next cycle, result=0; 5 extra shifts leave result=0.
//   5. data_in=8'hFF, load, shift -> result steps 1..8, done after the 8th shift, result=8 (4'b1000).
//   6. Mid-count: load 8'hFF, 3 shifts (result=3), then load 8'h01 with shift also high ->
//      A=01, result=0 (load wins); 1 shift -> result=1, done=1.
//      Then reset during a new count -> A=0, result=0.

Source files
------------

// File: rtl/ones_counter_datapath.sv
// Ones-counter datapath: shift register plus ones accumulator.
// Ports: clock, reset_datapath (sync, active-high), load_A, shift,
//   data_in[N-1:0] in; done_datapath, result[CW-1:0], A_out[N-1:0] out.
module ones_counter_datapath #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset_datapath,
  input  logic          load_A,
  input  logic          shift,
  input  logic [N-1:0]  data_in,
  output logic          done_datapath,
  output logic [CW-1:0] result,
  output logic [N-1:0]  A_out
);

  logic [N-1:0]  A_q;
  logic [N-1:0]  A_d;
  logic [CW-1:0] result_q;
  logic [CW-1:0] result_d;

  // Shifting stops once A is empty, so leading zeros are
  // never visited and the count cannot run past N.
  always_comb begin
    A_d      = A_q;
    result_d = result_q;
    if (load_A) begin
      A_d      = data_in;
      result_d = '0;
    end else if (shift && (A_q != '0)) begin
      A_d      = {1'b0, A_q[N-1:1]};
      result_d = result_q + {{(CW-1){1'b0}}, A_q[0]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset_datapath) begin
      A_q      <= '0;
      result_q <= '0;
    end else begin
      A_q      <= A_d;
      result_q <= result_d;
    end
  end

  assign done_datapath = (A_q == '0);
  assign result        = result_q;
  assign A_out         = A_q;

endmodule

// File: tb/tb_ones_counter_datapath.sv
// Bench for ones_counter_datapath: directed steps with
// hand-computed expectations checked by a scoreboard monitor.
module tb_ones_counter_datapath;

  typedef struct packed {
    logic [7:0] a;
    logic [3:0] r;
    logic       d;
  } exp_t;

  logic       clock;
  logic       reset_datapath;
  logic       load_A;
  logic       shift;
  logic [7:0] data_in;
  logic       done_datapath;
  logic [3:0] result;
  logic [7:0] A_out;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  ones_counter_datapath #(.N(8)) dut (
    .clock          (clock),
    .reset_datapath (reset_datapath),
    .load_A         (load_A),
    .shift          (shift),
    .data_in        (data_in),
    .done_datapath  (done_datapath),
    .result         (result),
    .A_out          (A_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One edge of stimulus; expected post-edge state is queued.
  task automatic step(
    input logic       r,
    input logic       l,
    input logic       s,
    input logic [7:0] d,
    input logic [7:0] ea,
    input logic [3:0] er,
    input logic       ed
  );
    exp_t e;
    @(negedge clock);
    reset_datapath = r;
    load_A         = l;
    shift          = s;
    data_in        = d;
    e.a = ea;
    e.r = er;
    e.d = ed;
    sb_q.push_back(e);
  endtask

  // Monitor: every edge with a queued expectation is checked.
  always begin
    exp_t e;
    @(posedge clock);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (A_out !== e.a || result !== e.r ||
          done_datapath !== e.d) begin
        errors++;
        $display("FAIL check%0d: got A=%h r=%0d d=%b want A=%h r=%0d d=%b",
                 checks, A_out, result, done_datapath,
                 e.a, e.r, e.d);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset_datapath = 1'b0;
    load_A  = 1'b0;
    shift   = 1'b0;
    data_in = 8'h00;

    // reset
    step(1, 0, 0, 8'h3C, 8'h00, 0, 1);
    step(0, 0, 0, 8'h3C, 8'h00, 0, 1);
    // 1011_0100, data_in wiggles while shifting
    step(0, 1, 0, 8'hB4, 8'hB4, 0, 0);
    step(0, 0, 1, 8'hFF, 8'h5A, 0, 0);
    step(0, 0, 1, 8'h00, 8'h2D, 0, 0);
    step(0, 0, 1, 8'hFF, 8'h16, 1, 0);
    step(0, 0, 1, 8'h11, 8'h0B, 1, 0);
    step(0, 0, 1, 8'hFF, 8'h05, 2, 0);
    step(0, 0, 1, 8'h00, 8'h02, 3, 0);
    step(0, 0, 1, 8'hFF, 8'h01, 3, 0);
    step(0, 0, 1, 8'h80, 8'h00, 4, 1);
    step(0, 0, 1, 8'hFF, 8'h00, 4, 1);
    step(0, 0, 1, 8'hFF, 8'h00, 4, 1);
    // early exit
    step(0, 1, 0, 8'h05, 8'h05, 0, 0);
    step(0, 0, 1, 8'h05, 8'h02, 1, 0);
    step(0, 0, 1, 8'h05, 8'h01, 1, 0);
    step(0, 0, 1, 8'h05, 8'h00, 2, 1);
    // zero word
    step(0, 1, 0, 8'h00, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 8'h00, 8'h00, 0, 1);
    // all ones
    step(0, 1, 0, 8'hFF, 8'hFF, 0, 0);
    step(0, 0, 1, 8'hFF, 8'h7F, 1, 0);
    step(0, 0, 1, 8'hFF, 8'h3F, 2, 0);
    step(0, 0, 1, 8'hFF, 8'h1F, 3, 0);
    step(0, 0, 1, 8'hFF, 8'h0F, 4, 0);
    step(0, 0, 1, 8'hFF, 8'h07, 5, 0);
    step(0, 0, 1, 8'hFF, 8'h03, 6, 0);
    step(0, 0, 1, 8'hFF, 8'h01, 7, 0);
    step(0, 0, 1, 8'hFF, 8'h00, 8, 1);
    step(0, 0, 1, 8'hFF, 8'h00, 8, 1);
    // reload mid-count, load beats shift
    step(0, 1, 0, 8'hFF, 8'hFF, 0, 0);
    step(0, 0, 1, 8'hFF, 8'h7F, 1, 0);
    step(0, 0, 1, 8'hFF, 8'h3F, 2, 0);
    step(0, 0, 1, 8'hFF, 8'h1F, 3, 0);
    step(0, 1, 1, 8'h01, 8'h01, 0, 0);
    step(0, 0, 1, 8'h01, 8'h00, 1, 1);
    // idle hold
    step(0, 1, 0, 8'h03, 8'h03, 0, 0);
    step(0, 0, 0, 8'hF0, 8'h03, 0, 0);
    step(0, 0, 1, 8'hF0, 8'h01, 1, 0);
    step(0, 0, 0, 8'hF0, 8'h01, 1, 0);
    // reset mid-count wins over load and shift
    step(0, 1, 0, 8'hAA, 8'hAA, 0, 0);
    step(0, 0, 1, 8'hAA, 8'h55, 0, 0);
    step(0, 0, 1, 8'hAA, 8'h2A, 1, 0);
    step(1, 1, 1, 8'hFF, 8'h00, 0, 1);
    step(0, 0, 0, 8'hFF, 8'h00, 0, 1);

    @(negedge clock);
    load_A = 1'b0;
    shift  = 1'b0;
    @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
